// File: rtl/aoc5_pair_batcher_if.sv
`default_nettype none
// ============================================================================
// Module      : aoc5_pair_batcher_if
// Description : Handshake and issue bus between the range parser, the pair
//               batcher and the 16-entry bitonic sorter.
// Revision    : 1.0 - initial release
// ============================================================================
interface aoc5_pair_batcher_if #(
    parameter int PAIR_W = 64
);
    localparam int ARR_16_FLAT_WIDTH = 16 * PAIR_W;

    // Upstream side: one range per handshake.
    logic                         in_valid;
    logic                         in_ready;
    logic [PAIR_W-1:0]            in_pair;
    logic                         in_last;

    // Sorter side: a batch is presented on two back-to-back beats.
    logic                         out_valid;
    logic [ARR_16_FLAT_WIDTH-1:0] pairs_out_flat;
    logic [4:0]                   out_count;
    logic                         out_last;
    logic [15:0]                  batches_issued;

    // Producer of pairs and consumer of batches.
    modport master (
        output in_valid, in_pair, in_last,
        input  in_ready, out_valid, pairs_out_flat, out_count, out_last,
               batches_issued
    );

    // The batcher itself.
    modport slave (
        input  in_valid, in_pair, in_last,
        output in_ready, out_valid, pairs_out_flat, out_count, out_last,
               batches_issued
    );
endinterface
`default_nettype wire

// File: rtl/aoc5_pair_batcher.sv
`default_nettype none
// ============================================================================
// Module      : aoc5_pair_batcher
// Description : Packs incoming ranges into 16-slot batches, pads short final
//               batches with a sentinel and issues each batch to the bitonic
//               sorter as two consecutive valid beats with stable data.
// Revision    : 1.0 - initial release
// ============================================================================
module aoc5_pair_batcher #(
    parameter int                PAIR_W    = 64,
    parameter logic [PAIR_W-1:0] PAD_VALUE = '1,
    parameter int                ISSUE_GAP = 0
) (
    input  wire logic          clock,
    input  wire logic          reset,
    aoc5_pair_batcher_if.slave bus
);

    localparam int c_SLOTS = 16;
    localparam int c_GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST =
        c_GAP_W'((ISSUE_GAP > 0) ? (ISSUE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_ISSUE_LO = 2'd1,
        S_ISSUE_HI = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [4:0]         r_fill;
    logic [4:0]         w_fill_inc;
    logic [4:0]         r_out_count;
    logic               r_batch_last;
    logic [15:0]        r_batches_issued;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               w_hs;
    logic               w_close;

    // in_ready is registered, so a handshake can only happen in FILL.
    assign w_hs       = bus.in_valid && r_in_ready;
    assign w_fill_inc = r_fill + 5'd1;
    assign w_close    = w_hs && ((w_fill_inc == 5'(c_SLOTS)) || bus.in_last);

    // Next-state decode for the fill / two-beat issue / gap sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL: begin
                if (w_close) begin
                    w_next_state = S_ISSUE_LO;
                end
            end
            S_ISSUE_LO: begin
                w_next_state = S_ISSUE_HI;
            end
            S_ISSUE_HI: begin
                w_next_state = (ISSUE_GAP > 0) ? S_GAP : S_FILL;
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next_state = S_FILL;
                end
            end
            default: begin
                w_next_state = S_FILL;
            end
        endcase
    end

    // State register with handshake outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == S_FILL);
            r_out_valid <= (w_next_state == S_ISSUE_LO) ||
                           (w_next_state == S_ISSUE_HI);
        end
    end

    // Idle-cycle counter, running only while in GAP.
    always_ff @(posedge clock) begin
        if (reset || (r_state != S_GAP)) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Fill level, batch descriptors and the running issued-batch count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fill           <= 5'd0;
            r_out_count      <= 5'd0;
            r_batch_last     <= 1'b0;
            r_batches_issued <= 16'd0;
        end else if (r_state == S_ISSUE_HI) begin
            r_fill           <= 5'd0;
            r_batches_issued <= r_batches_issued + 16'd1;
        end else if (w_hs) begin
            r_fill <= w_fill_inc;
            if (w_close) begin
                r_out_count  <= w_fill_inc;
                r_batch_last <= bus.in_last;
            end
        end
    end

    // One register per slot: capture the pair at the fill pointer, and on the
    // closing handshake overwrite every slot past the new fill level with pad.
    for (genvar i = 0; i < c_SLOTS; i++) begin : g_slot
        localparam logic [4:0] c_IDX = 5'(i);
        logic [PAIR_W-1:0] r_slot;

        // Slot write: new pair, pad on close, or hold.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_slot <= '0;
            end else if (w_hs) begin
                if (r_fill == c_IDX) begin
                    r_slot <= bus.in_pair;
                end else if (w_close && (c_IDX >= w_fill_inc)) begin
                    r_slot <= PAD_VALUE;
                end
            end
        end

        assign bus.pairs_out_flat[i*PAIR_W +: PAIR_W] = r_slot;
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.out_valid      = r_out_valid;
    assign bus.out_count      = r_out_count;
    assign bus.out_last       = r_batch_last;
    assign bus.batches_issued = r_batches_issued;

endmodule
`default_nettype wire

// File: tb/tb_aoc5_pair_batcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_aoc5_pair_batcher
// Description : Self-checking bench for aoc5_pair_batcher with a queue-based
//               batching model; two instances cover ISSUE_GAP of 0 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aoc5_pair_batcher;
    localparam int PW = 64;
    localparam int FW = 16 * PW;
    localparam logic [PW-1:0] PAD = '1;

    typedef struct {
        logic [FW-1:0] flat;
        logic [4:0]    count;
        logic          last;
        int            cyc;
        logic [15:0]   issued;
    } beat_t;

    typedef struct {
        logic [FW-1:0] flat;
        logic [4:0]    count;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    beat_t         beats0[$];
    beat_t         beats3[$];
    exp_t          exp0[$];
    exp_t          exp3[$];
    logic [PW-1:0] part0[$];
    logic [PW-1:0] part3[$];
    logic [15:0]   iss0 = 16'd0;
    logic [15:0]   iss3 = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aoc5_pair_batcher_if #(.PAIR_W(PW)) bus0 ();
    aoc5_pair_batcher_if #(.PAIR_W(PW)) bus3 ();

    aoc5_pair_batcher #(.PAIR_W(PW), .PAD_VALUE(PAD), .ISSUE_GAP(0)) dut0 (
        .clock (clk),
        .reset (rst),
        .bus   (bus0)
    );

    aoc5_pair_batcher #(.PAIR_W(PW), .PAD_VALUE(PAD), .ISSUE_GAP(3)) dut3 (
        .clock (clk),
        .reset (rst),
        .bus   (bus3)
    );

    // Record every issue beat of both instances.
    always @(negedge clk) begin
        if (bus0.out_valid === 1'b1)
            beats0.push_back('{bus0.pairs_out_flat, bus0.out_count, bus0.out_last, cyc, bus0.batches_issued});
        if (bus3.out_valid === 1'b1)
            beats3.push_back('{bus3.pairs_out_flat, bus3.out_count, bus3.out_last, cyc, bus3.batches_issued});
    end

    function automatic exp_t make_exp(input logic [PW-1:0] q[$], input logic last);
        exp_t e;
        e.flat = '0;
        for (int i = 0; i < 16; i++)
            e.flat[i*PW +: PW] = (i < q.size()) ? q[i] : PAD;
        e.count = 5'(q.size());
        e.last  = last;
        return e;
    endfunction

    // Batching rule: a batch closes after 16 pairs or on the pair marked last.
    function automatic void model_accept(input int w, input logic [PW-1:0] p, input logic last);
        if (w == 0) begin
            part0.push_back(p);
            if (part0.size() == 16 || last) begin
                exp0.push_back(make_exp(part0, last));
                part0.delete();
            end
        end else begin
            part3.push_back(p);
            if (part3.size() == 16 || last) begin
                exp3.push_back(make_exp(part3, last));
                part3.delete();
            end
        end
    endfunction

    function automatic logic rdy(input int w);
        return (w == 0) ? bus0.in_ready : bus3.in_ready;
    endfunction

    task automatic clear_model();
        beats0.delete(); beats3.delete();
        exp0.delete();   exp3.delete();
        part0.delete();  part3.delete();
        iss0 = 16'd0;    iss3 = 16'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Offer one pair and hold it until accepted; waits = cycles refused.
    task automatic send(input int w, input logic [PW-1:0] p, input logic last, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        if (w == 0) begin bus0.in_valid = 1'b1; bus0.in_pair = p; bus0.in_last = last; end
        else        begin bus3.in_valid = 1'b1; bus3.in_pair = p; bus3.in_last = last; end
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (rdy(w) === 1'b1) done = 1'b1;
            else                 waits++;
            @(posedge clk); #1;
        end
        if (done) begin
            model_accept(w, p, last);
        end else begin
            total++; bad++;
            $display("FAIL send_timeout dut%0d: in_ready stayed %b, need 1", w, rdy(w));
        end
        if (w == 0) begin bus0.in_valid = 1'b0; bus0.in_last = 1'b0; end
        else        begin bus3.in_valid = 1'b0; bus3.in_last = 1'b0; end
    endtask

    task automatic stream(input int w, input int n, input bit last_at_end, input int maxgap);
        int wt;
        for (int i = 0; i < n; i++) begin
            send(w, {$urandom, $urandom}, last_at_end && (i == n - 1), wt);
            if (maxgap > 0) idle($urandom_range(maxgap, 0));
        end
    endtask

    // Compare recorded beats against the modelled batches, then clear both.
    task automatic drain(input int w, input string name);
        beat_t       b[$];
        exp_t        e[$];
        beat_t       b0, b1;
        exp_t        ex;
        logic [15:0] iss;
        int          k, bs;
        k = 0;
        while (k < 200 && ((w == 0) ? beats0.size() < 2 * exp0.size()
                                     : beats3.size() < 2 * exp3.size())) begin
            @(posedge clk); #1; k++;
        end
        idle(4);
        if (w == 0) begin b = beats0; e = exp0; iss = iss0; end
        else        begin b = beats3; e = exp3; iss = iss3; end
        total++;
        if (b.size() != 2 * e.size()) begin
            bad++;
            $display("FAIL %s beat_count: got %0d beats, need %0d", name, b.size(), 2 * e.size());
        end
        for (int j = 0; j < e.size() && 2 * j + 1 < b.size(); j++) begin
            b0 = b[2*j]; b1 = b[2*j+1]; ex = e[j];
            total++;
            if (b1.cyc != b0.cyc + 1) begin
                bad++;
                $display("FAIL %s beat_pairing batch %0d: beats at cycles %0d,%0d, need adjacent", name, j, b0.cyc, b1.cyc);
            end
            bs = -1;
            for (int s = 15; s >= 0; s--)
                if (b0.flat[s*PW +: PW] !== ex.flat[s*PW +: PW] || b1.flat[s*PW +: PW] !== ex.flat[s*PW +: PW]) bs = s;
            total++;
            if (bs >= 0) begin
                bad++;
                $display("FAIL %s data batch %0d slot %0d: got %h/%h, need %h", name, j, bs,
                         b0.flat[bs*PW +: PW], b1.flat[bs*PW +: PW], ex.flat[bs*PW +: PW]);
            end
            total++;
            if (b0.count !== ex.count || b1.count !== ex.count) begin
                bad++;
                $display("FAIL %s out_count batch %0d: got %0d/%0d, need %0d", name, j, b0.count, b1.count, ex.count);
            end
            total++;
            if (b0.last !== ex.last || b1.last !== ex.last) begin
                bad++;
                $display("FAIL %s out_last batch %0d: got %b/%b, need %b", name, j, b0.last, b1.last, ex.last);
            end
            total++;
            if (b0.issued !== iss || b1.issued !== iss) begin
                bad++;
                $display("FAIL %s batches_issued batch %0d: got %0d/%0d, need %0d", name, j, b0.issued, b1.issued, iss);
            end
            iss = iss + 16'd1;
        end
        if (e.size() > b.size() / 2) iss = iss + 16'(e.size() - b.size() / 2);
        total++;
        if (((w == 0) ? bus0.batches_issued : bus3.batches_issued) !== iss) begin
            bad++;
            $display("FAIL %s final_batches_issued: got %0d, need %0d", name,
                     (w == 0) ? bus0.batches_issued : bus3.batches_issued, iss);
        end
        if (w == 0) begin beats0.delete(); exp0.delete(); iss0 = iss; end
        else        begin beats3.delete(); exp3.delete(); iss3 = iss; end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (bus0.in_ready !== 1'b1)       begin bad++; $display("FAIL reset in_ready: got %b need 1", bus0.in_ready); end
        total++; if (bus0.out_valid !== 1'b0)      begin bad++; $display("FAIL reset out_valid: got %b need 0", bus0.out_valid); end
        total++; if (bus0.out_count !== 5'd0)      begin bad++; $display("FAIL reset out_count: got %0d need 0", bus0.out_count); end
        total++; if (bus0.out_last !== 1'b0)       begin bad++; $display("FAIL reset out_last: got %b need 0", bus0.out_last); end
        total++; if (bus0.batches_issued !== 16'd0) begin bad++; $display("FAIL reset batches_issued: got %0d need 0", bus0.batches_issued); end
        total++; if (bus0.pairs_out_flat !== '0)   begin bad++; $display("FAIL reset pairs_out_flat: nonzero, need 0"); end
        total++; if (bus3.in_ready !== 1'b1)       begin bad++; $display("FAIL reset gap3 in_ready: got %b need 1", bus3.in_ready); end
        total++; if (bus3.out_valid !== 1'b0)      begin bad++; $display("FAIL reset gap3 out_valid: got %b need 0", bus3.out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_batch();
        int low, ov;
        logic first_ov;
        stream(0, 16, 1'b0, 0);
        low = 0; ov = 0; first_ov = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus0.in_ready !== 1'b1) low++;
            if (bus0.out_valid === 1'b1) ov++;
            if (c == 0) first_ov = bus0.out_valid;
        end
        total++; if (first_ov !== 1'b1) begin bad++; $display("FAIL full latency: out_valid after closing edge %b, need 1", first_ov); end
        total++; if (low != 2) begin bad++; $display("FAIL full in_ready_low: got %0d cycles, need 2", low); end
        total++; if (ov != 2)  begin bad++; $display("FAIL full out_valid_len: got %0d cycles, need 2", ov); end
        drain(0, "full");
    endtask

    task automatic test_short_flush();
        stream(0, 5, 1'b1, 0);
        drain(0, "short5");
        stream(0, 16, 1'b1, 1);
        drain(0, "last16");
    endtask

    task automatic test_backpressure();
        int wt;
        stream(0, 4, 1'b1, 0);
        send(0, {32'hCAFE0000, 32'hCAFE0001}, 1'b0, wt);
        total++; if (wt != 2) begin bad++; $display("FAIL bp_gap0 held_wait: got %0d, need 2", wt); end
        send(0, {32'hCAFE0002, 32'hCAFE0003}, 1'b1, wt);
        drain(0, "bp_gap0");
        stream(3, 4, 1'b1, 0);
        send(3, {32'hBEEF0000, 32'hBEEF0001}, 1'b0, wt);
        total++; if (wt != 5) begin bad++; $display("FAIL bp_gap3 held_wait: got %0d, need 5", wt); end
        stream(3, 15, 1'b0, 0);
        drain(3, "bp_gap3");
    endtask

    task automatic test_bubbles();
        stream(0, 40, 1'b1, 3);
        drain(0, "bubbles40");
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        stream(0, 3, 1'b1, 0);
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid first_beat: got %b need 1", bus0.out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus0.out_valid !== 1'b0)       begin bad++; $display("FAIL rst_mid out_valid: got %b need 0", bus0.out_valid); end
        total++; if (bus0.in_ready !== 1'b1)        begin bad++; $display("FAIL rst_mid in_ready: got %b need 1", bus0.in_ready); end
        total++; if (bus0.batches_issued !== 16'd0) begin bad++; $display("FAIL rst_mid batches_issued: got %0d need 0", bus0.batches_issued); end
        total++; if (bus0.out_count !== 5'd0)       begin bad++; $display("FAIL rst_mid out_count: got %0d need 0", bus0.out_count); end
        idle(5);
        total++; if (beats0.size() != 1) begin bad++; $display("FAIL rst_mid beats: got %0d, need 1", beats0.size()); end
        clear_model();
    endtask

    task automatic test_random();
        int w, n;
        for (int r = 0; r < 4; r++) begin
            w = ($urandom_range(1, 0) == 0) ? 0 : 3;
            n = $urandom_range(40, 1);
            stream(w, n, 1'b1, 2);
            drain(w, "random");
        end
    endtask

    task automatic test_end_to_end();
        logic [PW-1:0] vals[$];
        logic [PW-1:0] ref_q[$];
        logic [PW-1:0] got_q[$];
        logic [FW-1:0] f;
        int wt, k, bs;
        for (int i = 0; i < 13; i++) vals.push_back({32'(i * 7 + 1), 32'(i * 7 + 5)});
        vals.shuffle();
        for (int i = 0; i < 13; i++) send(0, vals[i], (i == 12), wt);
        k = 0;
        while (k < 50 && beats0.size() < 1) begin @(posedge clk); #1; k++; end
        total++;
        if (beats0.size() < 1) begin
            bad++; $display("FAIL e2e no_beat: got 0 beats, need 2");
        end else begin
            f = beats0[0].flat;
            for (int s = 0; s < 16; s++) got_q.push_back(f[s*PW +: PW]);
            got_q.sort();
            ref_q = vals;
            ref_q.sort();
            for (int s = 0; s < 3; s++) ref_q.push_back(PAD);
            bs = -1;
            for (int s = 15; s >= 0; s--) if (got_q[s] !== ref_q[s]) bs = s;
            if (bs >= 0) begin
                bad++; $display("FAIL e2e sorted slot %0d: got %h, need %h", bs, got_q[bs], ref_q[bs]);
            end
        end
        drain(0, "e2e");
    endtask

    initial begin
        bus0.in_valid = 1'b0; bus0.in_pair = '0; bus0.in_last = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_pair = '0; bus3.in_last = 1'b0;
        test_reset();
        test_full_batch();
        test_short_flush();
        test_backpressure();
        test_bubbles();
        test_reset_mid_issue();
        test_random();
        test_end_to_end();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
